// File: rtl/gs_pkg.sv
// Shared definitions for the Goldschmidt divide/sqrt front end: op encoding,
// issue-stage states and the iteration counts the datapath controllers also use.
package gs_pkg;

    localparam logic [1:0] OP_DIV = 2'b00;

    localparam int unsigned DIV_CYCLES  = 12;
    localparam int unsigned SQRT_CYCLES = 16;
    localparam int unsigned BUSY_W      = $clog2(SQRT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ISSUE = 2'd2,
        BUSY  = 2'd3
    } state_t;

    // Busy-window length minus one; the counter runs down to zero inclusive.
    function automatic logic [BUSY_W-1:0] busy_load(input logic [1:0] op);
        return (op == OP_DIV) ? BUSY_W'(DIV_CYCLES - 1) : BUSY_W'(SQRT_CYCLES - 1);
    endfunction

endpackage

// File: rtl/gs_norm_step.sv
// One normalisation step toward the UQ1.(WIDTH-1) range [0.5,1): a right shift
// for an overflowed operand, a left shift for a small one, otherwise hold.
module gs_norm_step #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned CNT_W = 7
) (
    input  logic [WIDTH-1:0]        sig,
    input  logic signed [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0]        sig_next_c,
    output logic signed [CNT_W-1:0] cnt_next_c,
    output logic                    normed_c
);

    always_comb begin
        sig_next_c = sig;
        cnt_next_c = cnt;
        if (sig[WIDTH-1]) begin
            sig_next_c = sig >> 1;
            cnt_next_c = cnt - CNT_W'(1);
        end else if (!sig[WIDTH-2] && (sig != '0)) begin
            sig_next_c = sig << 1;
            cnt_next_c = cnt + CNT_W'(1);
        end
    end

    // Flag describes the stepped value so the caller can leave NORM on the same edge.
    assign normed_c = (sig_next_c[WIDTH-1:WIDTH-2] == 2'b01) || (sig_next_c == '0);

endmodule

// File: rtl/gs_prenorm.sv
// Operand pre-normalisation and issue stage for the Goldschmidt divide/sqrt
// datapath: normalises significands, folds sqrt exponent parity, times the op.
module gs_prenorm
    import gs_pkg::*;
#(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned EXPW  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [WIDTH-1:0]       a_sig,
    input  logic [WIDTH-1:0]       b_sig,
    input  logic signed [EXPW-1:0] a_exp,
    input  logic signed [EXPW-1:0] b_exp,
    output logic [WIDTH-1:0]       numerator,
    output logic [WIDTH-1:0]       denominator,
    output logic [1:0]             op_q,
    output logic signed [EXPW+1:0] exp_out,
    output logic                   start,
    output logic                   done,
    output logic                   zero_a,
    output logic                   zero_b
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 2;
    localparam int unsigned EW    = EXPW + 2;

    state_t                  state, state_d;
    logic [WIDTH-1:0]        a_r, b_r, a_d, b_d;
    logic signed [CNT_W-1:0] sa, sb, sa_d, sb_d;
    logic signed [EXPW-1:0]  ae_r, be_r, ae_d, be_d;
    logic [1:0]              op_d;
    logic [WIDTH-1:0]        num_d, den_d;
    logic signed [EW-1:0]    exp_d;
    logic                    start_d, done_d, za_d, zb_d;
    logic [BUSY_W-1:0]       cnt, cnt_d;

    logic [WIDTH-1:0]        a_n, b_n;
    logic signed [CNT_W-1:0] sa_n, sb_n;
    logic                    a_normed, b_normed;
    logic                    is_div;

    logic signed [EW-1:0]    exp_div_c, e_sq_c, e_adj_c, exp_sq_c;
    logic [WIDTH-1:0]        sq_sig_c;

    gs_norm_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step_a (
        .sig        (a_r),
        .cnt        (sa),
        .sig_next_c (a_n),
        .cnt_next_c (sa_n),
        .normed_c   (a_normed)
    );

    gs_norm_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step_b (
        .sig        (b_r),
        .cnt        (sb),
        .sig_next_c (b_n),
        .cnt_next_c (sb_n),
        .normed_c   (b_normed)
    );

    assign in_ready = (state == IDLE) && !reset;
    assign is_div   = (op_q == OP_DIV);

    // Result exponents from the stepped counts, valid on the NORM exit cycle.
    assign exp_div_c = EW'(ae_r) - EW'(be_r) - EW'(sa_n) + EW'(sb_n);
    assign e_sq_c    = EW'(ae_r) - EW'(sa_n);
    assign e_adj_c   = e_sq_c[0] ? (e_sq_c + EW'(1)) : e_sq_c;
    assign exp_sq_c  = e_adj_c >>> 1;
    assign sq_sig_c  = e_sq_c[0] ? (a_n >> 1) : a_n;

    always_comb begin
        state_d = state;
        a_d     = a_r;
        b_d     = b_r;
        sa_d    = sa;
        sb_d    = sb;
        ae_d    = ae_r;
        be_d    = be_r;
        op_d    = op_q;
        num_d   = numerator;
        den_d   = denominator;
        exp_d   = exp_out;
        start_d = 1'b0;
        done_d  = 1'b0;
        za_d    = zero_a;
        zb_d    = zero_b;
        cnt_d   = cnt;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a_sig;
                    b_d     = b_sig;
                    ae_d    = a_exp;
                    be_d    = b_exp;
                    op_d    = op;
                    sa_d    = '0;
                    sb_d    = '0;
                    za_d    = 1'b0;
                    zb_d    = 1'b0;
                    state_d = NORM;
                end
            end

            NORM: begin
                a_d  = a_n;
                sa_d = sa_n;
                if (is_div) begin
                    b_d  = b_n;
                    sb_d = sb_n;
                end
                if (a_normed && (!is_div || b_normed)) begin
                    if ((a_n == '0) || (is_div && (b_n == '0))) begin
                        // Zero operand: report and retire without waking the datapath.
                        za_d    = (a_n == '0);
                        zb_d    = is_div && (b_n == '0);
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (is_div) begin
                        num_d   = a_n;
                        den_d   = b_n;
                        exp_d   = exp_div_c;
                        start_d = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        num_d   = sq_sig_c;
                        den_d   = sq_sig_c;
                        exp_d   = exp_sq_c;
                        start_d = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                cnt_d   = busy_load(op_q);
                state_d = BUSY;
            end

            BUSY: begin
                cnt_d = cnt - BUSY_W'(1);
                if (cnt == BUSY_W'(1)) begin
                    done_d = 1'b1;
                end
                if (cnt == '0) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sa          <= '0;
            sb          <= '0;
            ae_r        <= '0;
            be_r        <= '0;
            op_q        <= '0;
            numerator   <= '0;
            denominator <= '0;
            exp_out     <= '0;
            start       <= 1'b0;
            done        <= 1'b0;
            zero_a      <= 1'b0;
            zero_b      <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_d;
            a_r         <= a_d;
            b_r         <= b_d;
            sa          <= sa_d;
            sb          <= sb_d;
            ae_r        <= ae_d;
            be_r        <= be_d;
            op_q        <= op_d;
            numerator   <= num_d;
            denominator <= den_d;
            exp_out     <= exp_d;
            start       <= start_d;
            done        <= done_d;
            zero_a      <= za_d;
            zero_b      <= zb_d;
            cnt         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gs_prenorm.sv
// Directed bench for gs_prenorm: an independent msb-position model fills a
// scoreboard queue at issue time; entries are checked on start and popped on done.
module tb_gs_prenorm;

    localparam int unsigned W  = 30;
    localparam int unsigned EX = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [W-1:0]         a_sig, b_sig;
    logic signed [EX-1:0] a_exp, b_exp;
    logic [W-1:0]         numerator, denominator;
    logic [1:0]           op_q;
    logic signed [EX+1:0] exp_out;
    logic                 start, done, zero_a, zero_b;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [11:0]  ex;
        logic [1:0]   op;
        logic         za;
        logic         zb;
        logic         special;
        int           k;
        int           n;
    } exp_t;

    exp_t sb_q[$];

    gs_prenorm #(.WIDTH(W), .EXPW(EX)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a_sig       (a_sig),
        .b_sig       (b_sig),
        .a_exp       (a_exp),
        .b_exp       (b_exp),
        .numerator   (numerator),
        .denominator (denominator),
        .op_q        (op_q),
        .exp_out     (exp_out),
        .start       (start),
        .done        (done),
        .zero_a      (zero_a),
        .zero_b      (zero_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Left-shift count that puts the msb at bit W-2 (negative means shift right).
    function automatic int nshift(input logic [W-1:0] s);
        for (int i = W - 1; i >= 0; i--) begin
            if (s[i]) return (W - 2) - i;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] nval(input logic [W-1:0] s, input int sh);
        if (sh < 0) return s >> 1;
        return s << sh;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int ae, input int be);
        exp_t r;
        int   sa, sbc, e;
        logic [W-1:0] an;
        sa  = nshift(a);
        sbc = (o == 2'b00) ? nshift(b) : 0;
        an  = nval(a, sa);
        r.op = o;
        if (o == 2'b00) begin
            r.special = (a == '0) || (b == '0);
            r.za  = (a == '0);
            r.zb  = (b == '0);
            r.k   = (iabs(sa) > iabs(sbc)) ? iabs(sa) : iabs(sbc);
            r.num = an;
            r.den = nval(b, sbc);
            r.ex  = 12'(ae - be - sa + sbc);
            r.n   = 12;
        end else begin
            r.special = (a == '0);
            r.za  = (a == '0);
            r.zb  = 1'b0;
            r.k   = iabs(sa);
            e     = ae - sa;
            if ((e & 1) != 0) begin
                an = an >> 1;
                e  = e + 1;
            end
            r.num = an;
            r.den = an;
            r.ex  = 12'(e / 2);
            r.n   = 16;
        end
        if (r.k < 1) r.k = 1;
        return r;
    endfunction

    // Offer one operand set, then follow it to done and score the whole window.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int ae, input int be, input bit hold);
        exp_t e;
        int   start_cyc, n_start, done_cyc;
        start_cyc = -1;
        n_start   = 0;
        done_cyc  = -1;
        for (int w = 0; w < 40 && in_ready !== 1'b1; w++) @(negedge clk);
        check("ready_wait", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        op       = o;
        a_sig    = a;
        b_sig    = b;
        a_exp    = EX'(ae);
        b_exp    = EX'(be);
        sb_q.push_back(model(o, a, b, ae, be));
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (hold) begin
                op    = 2'($urandom);
                a_sig = W'($urandom);
                b_sig = W'($urandom);
                a_exp = EX'($urandom);
                b_exp = EX'($urandom);
            end
            if (start === 1'b1) begin
                n_start++;
                start_cyc = c;
                check("numerator", 64'(numerator), 64'(sb_q[0].num));
                check("denominator", 64'(denominator), 64'(sb_q[0].den));
                check("exp_out", 64'($unsigned(exp_out)), 64'(sb_q[0].ex));
                check("op_q", 64'(op_q), 64'(sb_q[0].op));
            end
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        e = sb_q.pop_front();
        check("done_cycle", 64'(done_cyc), e.special ? 64'(e.k + 1) : 64'(e.k + 1 + e.n));
        check("start_cycle", 64'(start_cyc), e.special ? 64'(-1) : 64'(e.k + 1));
        check("start_count", 64'(n_start), e.special ? 64'(0) : 64'(1));
        check("zero_a", 64'(zero_a), 64'(e.za));
        check("zero_b", 64'(zero_b), 64'(e.zb));
        check("ready_at_done", 64'(in_ready), 64'(e.special));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(0));
        check("ready_after", 64'(in_ready), 64'(1));
    endtask

    initial begin
        int n_seen;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        int           rae, rbe;

        reset    = 1'b1;
        in_valid = 1'b0;
        op       = '0;
        a_sig    = '0;
        b_sig    = '0;
        a_exp    = '0;
        b_exp    = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'(0));
        check("rst_num", 64'(numerator), 64'(0));
        check("rst_den", 64'(denominator), 64'(0));
        check("rst_exp", 64'($unsigned(exp_out)), 64'(0));
        check("rst_start", 64'(start), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 64'(in_ready), 64'(1));

        run_op(2'b00, 30'h1000_0000, 30'h0400_0000, 0, 0, 1'b0);
        run_op(2'b01, 30'h1000_0000, 30'h2AAA_AAAA, 3, 0, 1'b0);
        run_op(2'b00, 30'h3000_0000, 30'h1000_0000, 5, -3, 1'b0);
        run_op(2'b00, 30'h1000_0000, 30'h0000_0000, 7, 1, 1'b0);
        run_op(2'b10, 30'h0000_0000, 30'h1234_5678, 4, 0, 1'b0);
        run_op(2'b11, 30'h0400_0000, 30'h0000_0000, 4, 0, 1'b0);
        run_op(2'b01, 30'h0000_0001, 30'h0000_0000, -7, 0, 1'b0);
        run_op(2'b00, 30'h2000_0000, 30'h0000_0003, -512, 511, 1'b0);
        run_op(2'b01, 30'h3FFF_FFFF, 30'h0000_0000, 0, 0, 1'b0);
        run_op(2'b00, 30'h0000_0000, 30'h0000_0010, 0, 0, 1'b0);

        // in_valid held through the busy window with churning operands.
        run_op(2'b00, 30'h0800_0000, 30'h1000_0000, 2, 1, 1'b1);
        run_op(2'b00, 30'h1234_5678, 30'h0000_8000, -20, 30, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom);
            ra  = W'($urandom) >> $urandom_range(0, 29);
            rb  = W'($urandom) >> $urandom_range(0, 29);
            rae = int'($urandom_range(0, 400)) - 200;
            rbe = int'($urandom_range(0, 400)) - 200;
            run_op(rop, ra, rb, rae, rbe, 1'b0);
        end

        // Reset in the fifth BUSY cycle drops the operation without done.
        for (int w = 0; w < 40 && in_ready !== 1'b1; w++) @(negedge clk);
        in_valid = 1'b1;
        op       = 2'b00;
        a_sig    = 30'h1800_0000;
        b_sig    = 30'h1400_0000;
        a_exp    = 10'sd9;
        b_exp    = 10'sd2;
        @(negedge clk);
        in_valid = 1'b0;
        n_seen   = 0;
        for (int c = 0; c < 40 && n_seen == 0; c++) begin
            if (start === 1'b1) n_seen = 1;
            else @(negedge clk);
        end
        check("rst_test_start_seen", 64'(n_seen), 64'(1));
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_num", 64'(numerator), 64'(0));
        check("midrst_den", 64'(denominator), 64'(0));
        check("midrst_exp", 64'($unsigned(exp_out)), 64'(0));
        check("midrst_opq", 64'(op_q), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_zero", 64'({zero_a, zero_b, start}), 64'(0));
        check("midrst_ready", 64'(in_ready), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 64'(in_ready), 64'(1));
        n_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1 || start === 1'b1) n_seen++;
            @(negedge clk);
        end
        check("midrst_no_done", 64'(n_seen), 64'(0));

        run_op(2'b00, 30'h1FFF_FFFF, 30'h1000_0001, 1, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
